// File: rtl/fib_seq_engine.sv
`default_nettype none
// ============================================================================
//  Module   : fib_seq_engine
//  Purpose  : Computes term n of a two-term additive recurrence
//             t[k+2] = t[k] + t[k+1] with Fibonacci (0,1), Lucas (2,1) or
//             caller-supplied seeds. Sits behind a req/busy method-call
//             handshake and reports per-term unsigned overflow.
//  Ports    : clk, reset (sync, active-high)
//             n_in, mode, seed0, seed1 : call arguments, sampled on accepted req
//             req                      : call request (pulse or level)
//             busy                     : high while a req would be ignored
//             done                     : one-cycle pulse, result/overflow valid
//             result, overflow         : term n and its overflow flag (held)
//  Options  : FIB_SATURATE_EN - when defined, overflowed terms saturate to
//             all-ones instead of wrapping modulo 2^WIDTH.
//  Revision : 1.0 - initial release
// ============================================================================
module fib_seq_engine #(
    parameter int WIDTH   = 32,
    parameter int N_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_WIDTH-1:0] n_in,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   seed0,
    input  logic [WIDTH-1:0]   seed1,
    input  logic               req,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               overflow
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_LOOP = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_cur;
    logic [WIDTH-1:0]   r_next;
    logic [N_WIDTH-1:0] r_i;
    logic [N_WIDTH-1:0] r_n;
    logic               r_ovf_cur;
    logic               r_ovf_next;

    logic [WIDTH-1:0]   w_term0;
    logic [WIDTH-1:0]   w_term1;
    logic [WIDTH:0]     w_sum;
    logic               w_sum_ovf;
    logic [WIDTH-1:0]   w_next_val;

    // Seed selection; the reserved mode falls back to Fibonacci.
    always_comb begin
        w_term0 = '0;
        w_term1 = WIDTH'(1);
        case (mode)
            2'd1: begin
                w_term0 = WIDTH'(2);
                w_term1 = WIDTH'(1);
            end
            2'd2: begin
                w_term0 = seed0;
                w_term1 = seed1;
            end
            default: begin
                w_term0 = '0;
                w_term1 = WIDTH'(1);
            end
        endcase
    end

    // One extra bit captures the carry-out of the running sum.
    assign w_sum     = {1'b0, r_cur} + {1'b0, r_next};
    // The new term is overflowed if it carried or if either operand already
    // was: once a term overflows, every later term inherits the flag.
    assign w_sum_ovf = r_ovf_next | r_ovf_cur | w_sum[WIDTH];

`ifdef FIB_SATURATE_EN
    localparam logic [WIDTH-1:0] c_all_ones = '1;
    assign w_next_val = w_sum_ovf ? c_all_ones : w_sum[WIDTH-1:0];
`else
    assign w_next_val = w_sum[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_cur      <= '0;
            r_next     <= WIDTH'(1);
            r_i        <= '0;
            r_n        <= '0;
            r_ovf_cur  <= 1'b0;
            r_ovf_next <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (req) begin
                        r_cur      <= w_term0;
                        r_next     <= w_term1;
                        r_n        <= n_in;
                        r_i        <= '0;
                        r_ovf_cur  <= 1'b0;
                        r_ovf_next <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= ST_LOOP;
                    end
                end
                ST_LOOP: begin
                    // Compare before increment so n = 2^N_WIDTH-1 finishes
                    // without the counter wrapping.
                    if (r_i == r_n) begin
                        result   <= r_cur;
                        overflow <= r_ovf_cur;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_cur      <= r_next;
                        r_next     <= w_next_val;
                        r_ovf_cur  <= r_ovf_next;
                        r_ovf_next <= w_sum_ovf;
                        r_i        <= r_i + N_WIDTH'(1);
                    end
                end
                default: begin
                    busy    <= 1'b1;
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fib_seq_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fib_seq_engine
//  Purpose  : Self-checking bench for fib_seq_engine. A call-timeline model
//             with exact 64-bit arithmetic predicts busy/done/result/overflow
//             every cycle; directed calls also check literal results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fib_seq_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  n_in = '0;
    logic [1:0]  mode = '0;
    logic [31:0] seed0 = '0;
    logic [31:0] seed1 = '0;
    logic        req = 1'b0;
    logic        busy, done, overflow;
    logic [31:0] result;

    // Small instance for the counter-boundary case n = 2^N_WIDTH-1.
    logic [2:0]  s_n = '0;
    logic [1:0]  s_mode = '0;
    logic [7:0]  s_seed0 = '0;
    logic [7:0]  s_seed1 = '0;
    logic        s_req = 1'b0;
    logic        s_busy, s_done, s_overflow;
    logic [7:0]  s_result;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fib_seq_engine #(.WIDTH(32), .N_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .n_in(n_in), .mode(mode),
        .seed0(seed0), .seed1(seed1), .req(req),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    fib_seq_engine #(.WIDTH(8), .N_WIDTH(3)) dut_s (
        .clk(clk), .reset(reset), .n_in(s_n), .mode(s_mode),
        .seed0(s_seed0), .seed1(s_seed1), .req(s_req),
        .busy(s_busy), .done(s_done), .result(s_result), .overflow(s_overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Exact term n using 64-bit arithmetic, then mapped to the WIDTH-bit view.
    function automatic void ref_term(input logic [1:0] md, input logic [63:0] s0,
                                     input logic [63:0] s1, input int n, input int w,
                                     output logic [63:0] r, output logic o);
        longint unsigned a, b, t, lim;
        case (md)
            2'd1:    begin a = 2;  b = 1;  end
            2'd2:    begin a = s0; b = s1; end
            default: begin a = 0;  b = 1;  end
        endcase
        for (int k = 0; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        lim = (64'd1 << w) - 1;
        o = (a > lim);
`ifdef FIB_SATURATE_EN
        r = o ? lim : (a & lim);
`else
        r = a & lim;
`endif
    endfunction

    // Call-timeline model for the main instance.
    logic        m_busy, m_done, m_ovf, m_pend_ovf;
    logic [31:0] m_result, m_pend_res;
    int          m_left;
    int          m_phase;   // 0: after reset, 1: accepting, 2: computing

    always @(posedge clk) begin
        logic [63:0] r;
        logic        o;
        if (reset) begin
            m_busy   <= 1'b1;
            m_done   <= 1'b0;
            m_result <= '0;
            m_ovf    <= 1'b0;
            m_phase  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_phase == 0) begin
                m_busy  <= 1'b0;
                m_phase <= 1;
            end else if (m_phase == 1) begin
                if (req) begin
                    ref_term(mode, {32'd0, seed0}, {32'd0, seed1}, int'(n_in), 32, r, o);
                    m_pend_res <= r[31:0];
                    m_pend_ovf <= o;
                    m_left     <= int'(n_in);
                    m_busy     <= 1'b1;
                    m_phase    <= 2;
                end
            end else begin
                if (m_left == 0) begin
                    m_done   <= 1'b1;
                    m_result <= m_pend_res;
                    m_ovf    <= m_pend_ovf;
                    m_busy   <= 1'b0;
                    m_phase  <= 1;
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
            chk("cyc_done", {63'd0, done}, {63'd0, m_done});
            chk("cyc_result", {32'd0, result}, {32'd0, m_result});
            chk("cyc_overflow", {63'd0, overflow}, {63'd0, m_ovf});
        end
    end

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk({nm, "_idle_timeout"}, 64'd1, 64'd0);
    endtask

    // Issue one call and check latency plus literal result/overflow.
    task automatic do_call(input string nm, input logic [1:0] md, input int n,
                           input logic [31:0] s0, input logic [31:0] s1,
                           input logic [31:0] exp_r, input logic exp_o);
        int cyc;
        wait_idle(nm);
        mode = md; n_in = 8'(n); seed0 = s0; seed1 = s1; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        // Scramble the arguments: the running call must not care.
        mode = 2'd1; n_in = 8'd3; seed0 = 32'hDEAD; seed1 = 32'hBEEF;
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, 64'(cyc), 64'(n + 2));
        chk({nm, "_result"}, {32'd0, result}, {32'd0, exp_r});
        chk({nm, "_overflow"}, {63'd0, overflow}, {63'd0, exp_o});
        chk({nm, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic small_call(input string nm, input logic [1:0] md, input int n,
                              input logic [7:0] s0, input logic [7:0] s1);
        int cyc = 0;
        logic [63:0] r;
        logic        o;
        while (s_busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        ref_term(md, {56'd0, s0}, {56'd0, s1}, n, 8, r, o);
        s_mode = md; s_n = 3'(n); s_seed0 = s0; s_seed1 = s1; s_req = 1'b1;
        @(negedge clk);
        s_req = 1'b0;
        cyc = 1;
        while (!s_done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, 64'(cyc), 64'(n + 2));
        chk({nm, "_result"}, {56'd0, s_result}, r);
        chk({nm, "_overflow"}, {63'd0, s_overflow}, {63'd0, o});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] r;
        logic        o;
        int          cyc;
        int          ndone;

        // Pin the model itself with hand-computed values.
        ref_term(2'd0, 0, 0, 10, 32, r, o);
        chk("model_fib10", r, 64'd55);
        ref_term(2'd0, 0, 0, 47, 32, r, o);
        chk("model_fib47", {r, 63'd0, o} >> 63 == 0 ? r : r, 64'd2971215073);
        ref_term(2'd1, 0, 0, 5, 32, r, o);
        chk("model_lucas5", r, 64'd11);

        // Reset held for three edges, then released.
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rel_busy_hi", {63'd0, busy}, 64'd1);
        chk("rel_done", {63'd0, done}, 64'd0);
        chk("rel_result", {32'd0, result}, 64'd0);
        @(negedge clk);
        chk("rel_busy_lo", {63'd0, busy}, 64'd0);

        // Fibonacci, then an immediate back-to-back call in the done cycle.
        do_call("fib10", 2'd0, 10, 0, 0, 32'd55, 1'b0);
        do_call("fib42", 2'd0, 42, 0, 0, 32'd267914296, 1'b0);
        do_call("fib47", 2'd0, 47, 0, 0, 32'd2971215073, 1'b0);
`ifdef FIB_SATURATE_EN
        do_call("fib48", 2'd0, 48, 0, 0, 32'hFFFF_FFFF, 1'b1);
        do_call("fib50", 2'd0, 50, 0, 0, 32'hFFFF_FFFF, 1'b1);
`else
        do_call("fib48", 2'd0, 48, 0, 0, 32'd512559680, 1'b1);
        do_call("fib50", 2'd0, 50, 0, 0, 32'd3996334433, 1'b1);
`endif
        do_call("lucas5", 2'd1, 5, 0, 0, 32'd11, 1'b0);
        do_call("cust_n0", 2'd2, 0, 32'd3, 32'd4, 32'd3, 1'b0);
        do_call("mode3_n6", 2'd3, 6, 0, 0, 32'd8, 1'b0);

        // Request while busy mid-computation is ignored.
        wait_idle("hs");
        mode = 2'd0; n_in = 8'd10; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        cyc = 1;
        repeat (4) begin
            @(negedge clk);
            cyc++;
        end
        n_in = 8'd20; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        cyc++;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("hs_latency", 64'(cyc), 64'd12);
        chk("hs_result", {32'd0, result}, 64'd55);
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("hs_extra_done", 64'(ndone), 64'd0);

        // Reset in the middle of an n=30 computation.
        wait_idle("rst");
        mode = 2'd0; n_in = 8'd30; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd1);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);
        do_call("fib7", 2'd0, 7, 0, 0, 32'd13, 1'b0);

        // Narrow instance: n at the counter maximum, and overflow that lives
        // only in the look-ahead term versus in term n itself.
        small_call("s_fib7", 2'd0, 7, 8'd0, 8'd0);
        chk("s_fib7_lit", {56'd0, s_result}, 64'd13);
        small_call("s_cust_n1", 2'd2, 1, 8'd200, 8'd100);
        chk("s_cust_n1_lit", {63'd0, s_overflow}, 64'd0);
        small_call("s_cust_n2", 2'd2, 2, 8'd200, 8'd100);
        small_call("s_cust_n7", 2'd2, 7, 8'd200, 8'd100);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fib_seq_engine.md
Name: fib_seq_engine

Overview:
Parametrised successor to the single-function Fibonacci method block. It computes the n-th term of a two-term additive recurrence: Fibonacci, Lucas, or user seeds. Width and index range are configurable, and overflow is reported. It sits behind the same req/busy method-call handshake used by the generated method blocks, so a caller FSM can invoke it and collect the result with its return value.

Parameters:
WIDTH, 32, data width of seeds, running terms and result (unsigned)
N_WIDTH, 8, width of the requested index n

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
n_in  in  N_WIDTH  requested index n; sampled on accepted req
mode  in  2  0=Fibonacci (0,1), 1=Lucas (2,1), 2=custom (seed0,seed1), 3=reserved, treated as 0
seed0  in  WIDTH  term 0 for mode 2; sampled on accepted req
seed1  in  WIDTH  term 1 for mode 2; sampled on accepted req
req  in  1  call request; one-cycle pulse or level
busy  out  1  high while not ready to accept req
done  out  1  one-cycle pulse when result and overflow are valid
result  out  WIDTH  term n; held until the next done
overflow  out  1  term n exceeded 2^WIDTH-1; held with result

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset is sampled on the rising clk edge.
- Reset values: busy=1, done=0, result=0, overflow=0. Internal: state=INIT, cur=0, next=1, i=0, ovf_cur=0, ovf_next=0.
- FSM states: INIT, IDLE, LOOP.
- INIT: lasts one cycle after reset deasserts, then goes to IDLE. busy falls to 0 at the INIT->IDLE edge.
- IDLE, req=1 at edge t:
  - cur<=term0 and next<=term1, per mode.
  - Latch n_in. i<=0. Clear ovf_cur and ovf_next. busy<=1.
  - state<=LOOP.
- IDLE, req=0: stay in IDLE; all outputs hold.
- LOOP, i<n:
  - cur<=next; next<=cur+next, unsigned, truncated to WIDTH; i<=i+1.
  - ovf_cur<=ovf_next.
  - ovf_next<=ovf_next | ovf_cur | carry-out of cur+next.
- LOOP, i==n:
  - result<=cur; overflow<=ovf_cur; done<=1; busy<=0; state<=IDLE.
- done is otherwise 0. It is never high for two consecutive cycles.
- Latency: req accepted in cycle t gives done high in cycle t+n+2, with busy=0 in that same cycle.
  - A req in the done cycle is accepted, so back-to-back calls are spaced n+2 cycles apart.
- n=0: result=term0 after 2 cycles; overflow=0.
- A req while busy=1 (INIT or LOOP) is ignored. It is neither queued nor latched. The caller must wait for busy=0.
- n_in, mode and seeds may change freely after acceptance without affecting the running computation.
- Overflow is tracked per term.
  - Overflow in next only, i.e. beyond term n, does not set the flag.
  - Once a term overflows, every later term is flagged.
- Reset mid-LOOP: the computation is abandoned and all reset values are restored. No done is issued.
  - A new call is possible only after busy returns to 0, two cycles after reset deasserts.
- Counter i is N_WIDTH bits wide. n=2^N_WIDTH-1 must terminate correctly, with no wrap before the compare.

Optional Feature:
FIB_SATURATE_EN:
- Defined: once any term overflows, that term is forced to 2^WIDTH-1 and stays there. Every later sum involving a saturated operand is also 2^WIDTH-1. result shows all-ones whenever overflow=1.
- Undefined: arithmetic wraps modulo 2^WIDTH. result is the truncated value and overflow is the only indication.

Test Plan:
- Reset release: hold reset 3 cycles, then release -> busy=1 for 1 cycle, then 0; done=0; result=0.
- Fibonacci: WIDTH=32, mode=0, n=10 -> done 12 cycles after req, result=55, overflow=0. Immediate re-req with n=42 -> result=267914296.
- Boundary: mode=0, n=47 -> result=2971215073, overflow=0. n=48 -> overflow=1, result=512559680 without FIB_SATURATE_EN, 0xFFFFFFFF with it.
- Modes and n=0: mode=1, n=5 -> result=11. mode=2, seed0=3, seed1=4, n=0 -> result=3 two cycles after req. mode=3, n=6 -> result=8.
- Handshake: pulse req with n=20 while busy=1, mid-LOOP -> ignored; the first result (n=10 run) is unaffected; exactly one done.
- Reset mid-op: assert reset during LOOP of an n=30 call -> no done; result=0, busy=1. New call n=7 after busy=0 -> result=13.
